// File: rtl/down_timer.sv
// down_timer: loadable W-bit down-counter with a valid/ready load port and a one-cycle done pulse.
// Define DOWN_TIMER_RELOAD_EN for periodic mode (reload value restored at each terminal count).
module down_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_valid,
   input  logic [W-1:0] load_val,
   output logic         load_ready,
   input  logic         enb,
   input  logic         abort,
   output logic [W-1:0] q,
   output logic         busy,
   output logic         done,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_q;
   logic [W-1:0] w_q_nxt;
   logic         r_done;
   logic         w_done_nxt;
   logic         w_accept;

   // Load handshake: a transfer happens on a rising edge where load_valid && load_ready;
   // load_ready depends only on state, and the source holds load_valid/load_val until then.
   assign load_ready = (r_state != S_RUN);
   assign w_accept   = load_valid && load_ready;

`ifdef DOWN_TIMER_RELOAD_EN
   logic [W-1:0] r_reload;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_reload <= '0;
      end else if (w_accept) begin
         r_reload <= load_val;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               if (load_val != '0) begin
                  w_q_nxt     = load_val;
                  w_state_nxt = S_RUN;
               end else begin
                  w_q_nxt     = '0;
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end
            end else if (r_state == S_DONE) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (abort) begin
               w_q_nxt     = '0;
               w_state_nxt = S_IDLE;
            end else if (enb) begin
               if (r_q > W'(1)) begin
                  w_q_nxt = r_q - W'(1);
               end else begin
                  // Terminal count; q never goes below zero.
                  w_done_nxt = 1'b1;
`ifdef DOWN_TIMER_RELOAD_EN
                  w_q_nxt     = r_reload;
`else
                  w_q_nxt     = '0;
                  w_state_nxt = S_DONE;
`endif
               end
            end
         end
         default: begin
            w_q_nxt     = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign q         = r_q;
   assign busy      = (r_state == S_RUN);
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed literal sequences plus randomized traffic checked every cycle
// against a count/running/done-pulse model of the timer.
module tb_down_timer;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         load_valid;
   logic [W-1:0] load_val;
   logic         load_ready;
   logic         enb;
   logic         abort;
   logic [W-1:0] q;
   logic         busy;
   logic         done;
   logic [1:0]   dbg_state;

   int checks = 0;
   int errors = 0;

   down_timer #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_val   (load_val),
      .load_ready (load_ready),
      .enb        (enb),
      .abort      (abort),
      .q          (q),
      .busy       (busy),
      .done       (done),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_q      = 0;
   int m_reload = 0;
   bit m_run    = 1'b0;
   bit m_done   = 1'b0;
   bit m_acc    = 1'b0;
   bit m_valid  = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_q     = 0;
         m_run   = 1'b0;
         m_done  = 1'b0;
         m_acc   = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_acc  = load_valid && !m_run;
         m_done = 1'b0;
         if (m_acc) begin
            m_reload = int'(load_val);
            if (load_val == 0) begin
               m_q    = 0;
               m_run  = 1'b0;
               m_done = 1'b1;
            end else begin
               m_q   = int'(load_val);
               m_run = 1'b1;
            end
         end else if (m_run) begin
            if (abort) begin
               m_q   = 0;
               m_run = 1'b0;
            end else if (enb) begin
               if (m_q == 1) begin
                  m_done = 1'b1;
`ifdef DOWN_TIMER_RELOAD_EN
                  m_q = m_reload;
`else
                  m_q   = 0;
                  m_run = 1'b0;
`endif
               end else begin
                  m_q = m_q - 1;
               end
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_q", int'(q), m_q);
         check("model_busy", int'(busy), int'(m_run));
         check("model_done", int'(done), int'(m_done));
         check("model_ready", int'(load_ready), int'(!m_run));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int v);
      load_valid = 1'b1;
      load_val   = W'(v);
      tick();
      load_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int exp_a[7];
   int exp_b[9];
   int cnt;

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_val   = '0;
      enb        = 1'b0;
      abort      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_q", int'(q), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_ready", int'(load_ready), 1);

`ifndef DOWN_TIMER_RELOAD_EN
      // load 3, continuous enable
      enb = 1'b1;
      load(3);
      check("l3_q3", int'(q), 3);
      check("l3_busy", int'(busy), 1);
      check("l3_ready", int'(load_ready), 0);
      tick(); check("l3_q2", int'(q), 2);
      tick(); check("l3_q1", int'(q), 1);
      check("l3_nodone", int'(done), 0);
      tick(); check("l3_q0", int'(q), 0);
      check("l3_done", int'(done), 1);
      check("l3_busy_lo", int'(busy), 0);
      tick(); check("l3_done_lo", int'(done), 0);
      check("l3_ready_hi", int'(load_ready), 1);

      // load 4 with gapped enable
      exp_a = '{4, 3, 3, 2, 2, 1, 0};
      load(4);
      check("l4_q0", int'(q), exp_a[0]);
      for (int i = 1; i < 7; i++) begin
         enb = (i == 2 || i == 4) ? 1'b0 : 1'b1;
         tick();
         check("l4_seq", int'(q), exp_a[i]);
         check("l4_done", int'(done), (i == 6) ? 1 : 0);
      end
      enb = 1'b1;
      tick();

      // abort mid-run
      load(5);
      tick(); tick();
      check("ab_q3", int'(q), 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_q", int'(q), 0);
      check("ab_busy", int'(busy), 0);
      check("ab_done", int'(done), 0);
      tick(); check("ab_done2", int'(done), 0);

      // reset mid-run
      load(5);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rs_q", int'(q), 0);
      check("rs_busy", int'(busy), 0);
      tick(); check("rs_done", int'(done), 0);

      // back-to-back: second load held through RUN, accepted in DONE
      load(2);
      load_valid = 1'b1;
      load_val   = W'(1);
      tick(); check("bb_q1", int'(q), 1);
      tick(); check("bb_done1", int'(done), 1);
      check("bb_ready", int'(load_ready), 1);
      tick(); check("bb_q_reload", int'(q), 1);
      check("bb_busy", int'(busy), 1);
      check("bb_gap", int'(done), 0);
      load_valid = 1'b0;
      tick(); check("bb_done2", int'(done), 1);
      tick();

      // load 0
      load(0);
      check("z_done", int'(done), 1);
      check("z_busy", int'(busy), 0);
      tick(); check("z_done_lo", int'(done), 0);

      // maximum load
      load(15);
      cnt = 0;
      while (done !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
      end
      check("max_cycles", cnt, 15);
      tick(); tick();
      check("max_nowrap", int'(q), 0);
`else
      // periodic mode: load 3 repeats 3,2,1 with a done on each reload
      exp_b = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
      enb = 1'b1;
      load(3);
      check("rl_q3", int'(q), 3);
      for (int i = 0; i < 9; i++) begin
         tick();
         check("rl_seq", int'(q), exp_b[i]);
         check("rl_done", int'(done), (exp_b[i] == 3) ? 1 : 0);
         check("rl_busy", int'(busy), 1);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("rl_ab_q", int'(q), 0);
      check("rl_ab_busy", int'(busy), 0);
      load(0);
      check("rl_z_done", int'(done), 1);
      check("rl_z_busy", int'(busy), 0);
      tick();
      check("rl_z_idle", int'(busy), 0);
`endif

      // randomized traffic; loads are held until the model reports acceptance
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         if (!load_valid || m_acc) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_val   = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 15))
                                                     : W'($urandom_range(0, 4));
         end
         enb   = ($urandom_range(0, 3) != 0);
         abort = ($urandom_range(0, 15) == 0);
         tick();
      end
      rst        = 1'b0;
      load_valid = 1'b0;
      abort      = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
